// File: rtl/seg_display_mux_pkg.sv
// Shared glyph constants, converter FSM encodings and helpers for the
// multiplexed seven-segment display driver.
package seg_pkg;

    typedef logic [3:0] bcd_nibble_t;

    // Active-low a..g patterns; bit 6 is segment g
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [6:0] seg_decode(input bcd_nibble_t nibble);
        logic [6:0] pattern;
        case (nibble)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] result;
        result = 64'd1;
        for (int i = 0; i < n; i++) begin
            result = result * 64'd10;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Numeric-source side of the display driver: value load strobe, display
// options and the registered segment/anode pins.
interface seg_display_mux_if #(
    parameter int N_DIGITS = 4,
    parameter int VAL_W    = 14
);
    logic [VAL_W-1:0]    value;
    logic                load;
    logic [N_DIGITS-1:0] dp;
    logic                blank_lz;
    logic                busy;
    logic                overflow;
    logic [7:0]          seg;
    logic [N_DIGITS-1:0] digit;

    modport master (
        output value, load, dp, blank_lz,
        input  busy, overflow, seg, digit
    );

    modport slave (
        input  value, load, dp, blank_lz,
        output busy, overflow, seg, digit
    );
endinterface

// File: rtl/seg_display_mux_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, then a
// single COMMIT cycle during which done_o is high and bcd_o holds the result.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VAL_W = 14,
    parameter int N_BCD = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [VAL_W-1:0]   value_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [4*N_BCD-1:0] bcd_o
);

    localparam int STEP_W = $clog2(VAL_W + 1);

    logic [1:0]         state_q, state_d;
    logic [VAL_W-1:0]   shift_q, shift_d;
    logic [4*N_BCD-1:0] acc_q, acc_d;
    logic [4*N_BCD-1:0] adjusted;
    logic [STEP_W-1:0]  step_q, step_d;

    always_comb begin
        adjusted = acc_q;
        for (int i = 0; i < N_BCD; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    shift_d = value_i;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                // The dropped top bit is always zero because N_BCD has a spare nibble
                acc_d   = (4*N_BCD)'({adjusted, shift_q[VAL_W-1]});
                shift_d = shift_q << 1;
                step_d  = step_q + 1'b1;
                if (step_q == STEP_W'(VAL_W - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_COMMIT);
    assign bcd_o  = acc_q;

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: captures a binary value, converts it to BCD
// in the background and scans N active-low common-anode digits.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int VAL_W    = 14,
    parameter int DIV      = 2500
) (
    input  logic clk,
    input  logic rst_n,
    seg_display_mux_if.slave bus
);

    localparam int          DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [63:0] OVF_LIMIT = pow10(N_DIGITS);

    logic                    start;
    logic                    convBusy;
    logic                    convDone;
    logic [4*N_DIGITS+3:0]   bcd;

    logic                    ovfPend_q, ovfPend_d;
    logic                    overflow_q, overflow_d;
    logic [4*N_DIGITS-1:0]   disp_q, disp_d;

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    tick;
    logic [IDX_W-1:0]        idx_q, idx_d, idxNext;
    logic [7:0]              seg_q, seg_d;
    logic [N_DIGITS-1:0]     digit_q, digit_d;
    logic [7:0]              glyph [N_DIGITS];

    assign start = bus.load & ~convBusy;

    bin2bcd_seq #(
        .VAL_W (VAL_W),
        .N_BCD (N_DIGITS + 1)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .value_i (bus.value),
        .busy_o  (convBusy),
        .done_o  (convDone),
        .bcd_o   (bcd)
    );

    // The spare nibble can only be non-zero when the capture compare already flagged overflow
    always_comb begin
        ovfPend_d  = ovfPend_q;
        overflow_d = overflow_q;
        disp_d     = disp_q;
        if (start) begin
            ovfPend_d = (64'(bus.value) >= OVF_LIMIT);
        end
        if (convDone) begin
            disp_d     = bcd[4*N_DIGITS-1:0];
            overflow_d = ovfPend_q | (bcd[4*N_DIGITS +: 4] != 4'd0);
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero
    always_comb begin
        logic        allZero;
        bcd_nibble_t nib;
        logic [6:0]  body;
        allZero = 1'b1;
        nib     = '0;
        body    = SEG_BLANK;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nib     = disp_q[4*i +: 4];
            allZero = allZero & (nib == 4'd0);
            if (overflow_q) begin
                body = SEG_DASH;
            end else if (bus.blank_lz && allZero && (i > 0)) begin
                body = SEG_BLANK;
            end else begin
                body = seg_decode(nib);
            end
            glyph[i] = {~bus.dp[i], body};
        end
    end

    assign tick    = (div_q == DIV_W'(DIV - 1));
    assign idxNext = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        idx_d   = idx_q;
        seg_d   = seg_q;
        digit_d = digit_q;
        if (tick) begin
            idx_d   = idxNext;
            seg_d   = glyph[idxNext];
            digit_d = ~(N_DIGITS'(1) << idxNext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfPend_q  <= 1'b0;
            overflow_q <= 1'b0;
            disp_q     <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            seg_q      <= 8'hFF;
            digit_q    <= '1;
        end else begin
            ovfPend_q  <= ovfPend_d;
            overflow_q <= overflow_d;
            disp_q     <= disp_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            digit_q    <= digit_d;
        end
    end

    assign bus.busy     = convBusy;
    assign bus.overflow = overflow_q;
    assign bus.seg      = seg_q;
    assign bus.digit    = digit_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: a 4-digit instance plus a 6-digit,
// 20-bit instance sharing clock and reset.
module tb_seg_display_mux;

    localparam int DIV4 = 4;
    localparam int DIV6 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seg_display_mux_if #(.N_DIGITS(4), .VAL_W(14)) bus4 ();
    seg_display_mux_if #(.N_DIGITS(6), .VAL_W(20)) bus6 ();

    seg_display_mux #(.N_DIGITS(4), .VAL_W(14), .DIV(DIV4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    seg_display_mux #(.N_DIGITS(6), .VAL_W(20), .DIV(DIV6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    function automatic logic [7:0] digitVec(input int which);
        return (which == 4) ? {4'hF, bus4.digit} : {2'b11, bus6.digit};
    endfunction

    // Waits for the scan to move onto digit idx from some other state
    task automatic waitDigit(input int which, input int idx, output bit ok);
        logic [7:0] target;
        bit         seenOther;
        target    = ~(8'h01 << idx);
        seenOther = 1'b0;
        ok        = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (digitVec(which) != target) begin
                seenOther = 1'b1;
            end else if (seenOther) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load4(input logic [13:0] v);
        @(negedge clk);
        bus4.value = v;
        bus4.load  = 1'b1;
        @(negedge clk);
        bus4.load  = 1'b0;
    endtask

    task automatic countBusy4(output int n);
        n = 0;
        while (bus4.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic scanFrame4(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] expSeg [4];
        bit         ok;
        expSeg[0] = e0; expSeg[1] = e1; expSeg[2] = e2; expSeg[3] = e3;
        for (int i = 0; i < 4; i++) begin
            waitDigit(4, i, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL %s_scan%0d digit never activated, digit=%h", name, i, bus4.digit);
            end else begin
                checks++;
                if (bus4.seg !== expSeg[i]) begin
                    failures++;
                    $display("[TB] FAIL %s_seg%0d got %h expected %h", name, i, bus4.seg, expSeg[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (bus4.seg !== 8'hFF) begin failures++; $display("[TB] FAIL rst_seg got %h expected ff", bus4.seg); end
        if (bus4.digit !== 4'hF) begin failures++; $display("[TB] FAIL rst_digit got %h expected f", bus4.digit); end
        if (bus4.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got %b expected 0", bus4.busy); end
        if (bus4.overflow !== 1'b0) begin failures++; $display("[TB] FAIL rst_ovf got %b expected 0", bus4.overflow); end
        if (bus6.digit !== 6'h3F) begin failures++; $display("[TB] FAIL rst_digit6 got %h expected 3f", bus6.digit); end
        rst_n = 1'b1;
        repeat (DIV4 - 1) @(negedge clk);
        checks++;
        if (bus4.digit !== 4'hF) begin failures++; $display("[TB] FAIL pre_tick_digit got %h expected f", bus4.digit); end
        @(negedge clk);
        checks += 2;
        if (bus4.digit !== 4'hD) begin failures++; $display("[TB] FAIL first_tick_digit got %h expected d", bus4.digit); end
        if (bus4.seg !== 8'hFF) begin failures++; $display("[TB] FAIL first_tick_seg got %h expected ff", bus4.seg); end
        scanFrame4("zero_blank", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        bus4.blank_lz = 1'b0;
        scanFrame4("zero_noblank", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        bus4.blank_lz = 1'b1;
    endtask

    task automatic test_convert;
        int n;
        load4(14'd4085);
        countBusy4(n);
        checks += 2;
        if (n != 15) begin failures++; $display("[TB] FAIL conv_busy_len got %0d expected 15", n); end
        if (bus4.overflow !== 1'b0) begin failures++; $display("[TB] FAIL conv_ovf got %b expected 0", bus4.overflow); end
        scanFrame4("v4085", 8'h92, 8'h80, 8'hC0, 8'h99);
    endtask

    task automatic test_overflow;
        int n;
        bus4.dp = 4'b0100;
        load4(14'd10000);
        countBusy4(n);
        checks += 2;
        if (n != 15) begin failures++; $display("[TB] FAIL ovf_busy_len got %0d expected 15", n); end
        if (bus4.overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got %b expected 1", bus4.overflow); end
        scanFrame4("ovf", 8'hBF, 8'hBF, 8'h3F, 8'hBF);
        bus4.dp = 4'b0000;
    endtask

    task automatic test_back_to_back;
        int run1, idle, run2;
        @(negedge clk);
        bus4.value = 14'd1111;
        bus4.load  = 1'b1;
        @(negedge clk);
        bus4.value = 14'd5678;
        countBusy4(run1);
        idle = 0;
        while (bus4.busy !== 1'b1 && idle < 10) begin
            idle++;
            @(negedge clk);
        end
        bus4.load = 1'b0;
        countBusy4(run2);
        checks += 4;
        if (run1 != 15) begin failures++; $display("[TB] FAIL b2b_run1 got %0d expected 15", run1); end
        if (idle != 1) begin failures++; $display("[TB] FAIL b2b_idle got %0d expected 1", idle); end
        if (run2 != 15) begin failures++; $display("[TB] FAIL b2b_run2 got %0d expected 15", run2); end
        if (bus4.overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ovf got %b expected 0", bus4.overflow); end
        scanFrame4("v5678", 8'h80, 8'hF8, 8'h82, 8'h92);
    endtask

    task automatic test_ignore_load;
        int n;
        load4(14'd7);
        n = 0;
        while (bus4.busy === 1'b1 && n < 100) begin
            n++;
            if (n == 5) begin
                bus4.value = 14'd9;
                bus4.load  = 1'b1;
            end else begin
                bus4.load  = 1'b0;
            end
            @(negedge clk);
        end
        bus4.load = 1'b0;
        repeat (3) @(negedge clk);
        checks += 2;
        if (n != 15) begin failures++; $display("[TB] FAIL ignore_busy_len got %0d expected 15", n); end
        if (bus4.busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_restart busy=%b expected 0", bus4.busy); end
        scanFrame4("v7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    endtask

    task automatic test_reset_mid;
        int n;
        int busySeen;
        load4(14'd1234);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus4.busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got %b expected 0", bus4.busy); end
        if (bus4.digit !== 4'hF) begin failures++; $display("[TB] FAIL midrst_digit got %h expected f", bus4.digit); end
        if (bus4.seg !== 8'hFF) begin failures++; $display("[TB] FAIL midrst_seg got %h expected ff", bus4.seg); end
        if (bus4.overflow !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ovf got %b expected 0", bus4.overflow); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        busySeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus4.busy !== 1'b0) busySeen++;
        end
        checks++;
        if (busySeen != 0) begin failures++; $display("[TB] FAIL midrst_no_commit busy cycles %0d expected 0", busySeen); end
        scanFrame4("after_rst", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        load4(14'd1234);
        countBusy4(n);
        checks++;
        if (n != 15) begin failures++; $display("[TB] FAIL reload_busy_len got %0d expected 15", n); end
        scanFrame4("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);
    endtask

    task automatic test_six_digits;
        int  n;
        bit  ok;
        @(negedge clk);
        bus6.value = 20'd999999;
        bus6.load  = 1'b1;
        @(negedge clk);
        bus6.load  = 1'b0;
        n = 0;
        while (bus6.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks += 2;
        if (n != 21) begin failures++; $display("[TB] FAIL six_busy_len got %0d expected 21", n); end
        if (bus6.overflow !== 1'b0) begin failures++; $display("[TB] FAIL six_ovf got %b expected 0", bus6.overflow); end
        for (int i = 0; i < 6; i++) begin
            waitDigit(6, i, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL six_scan%0d digit never activated, digit=%h", i, bus6.digit);
            end else begin
                checks++;
                if (bus6.seg !== 8'h90) begin failures++; $display("[TB] FAIL six_seg%0d got %h expected 90", i, bus6.seg); end
            end
        end
        waitDigit(6, 5, ok);
        n = 0;
        while (digitVec(6) == 8'hDF && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks += 2;
        if (digitVec(6) !== 8'hFE) begin failures++; $display("[TB] FAIL six_wrap digit got %h expected 3e", bus6.digit); end
        if (n != DIV6) begin failures++; $display("[TB] FAIL six_dwell got %0d expected %0d", n, DIV6); end
        n = 0;
        while (digitVec(6) == 8'hFE && n < 100) begin
            n++;
            @(negedge clk);
        end
        while (digitVec(6) != 8'hFE && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 6 * DIV6) begin failures++; $display("[TB] FAIL six_frame got %0d expected %0d", n, 6 * DIV6); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus4.value    = '0;
        bus4.load     = 1'b0;
        bus4.dp       = '0;
        bus4.blank_lz = 1'b1;
        bus6.value    = '0;
        bus6.load     = 1'b0;
        bus6.dp       = '0;
        bus6.blank_lz = 1'b1;
        test_reset();
        test_convert();
        test_overflow();
        test_back_to_back();
        test_ignore_load();
        test_reset_mid();
        test_six_digits();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
